// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataMem between the core and the loader.
// Optional DMEM_ARB_PERF_EN adds stall/grant performance counters.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       core_stall_cnt,
    output logic [15:0]       ldr_grant_cnt
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

    typedef enum logic {ARB, LOCKED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_LDR} owner_t;

    state_t        state, state_nxt;
    owner_t        rd_owner, rd_owner_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic          core_win, ldr_win;

    // Arbitration and lock next-state; no grants while in reset
    always_comb begin
        core_win  = 1'b0;
        ldr_win   = 1'b0;
        state_nxt = state;
        if (!rst) begin
            case (state)
                ARB: begin
                    if (ldr_req && (!core_req || starve_cnt == S_MAX))
                        ldr_win = 1'b1;
                    else if (core_req)
                        core_win = 1'b1;
                end
                LOCKED: ldr_win = ldr_req;
                default: ldr_win = 1'b0;
            endcase
            if (ldr_win)
                state_nxt = ldr_lock ? LOCKED : ARB;
            else if (!ldr_req)
                state_nxt = ARB;
        end
    end

    assign core_gnt = core_win;
    assign ldr_gnt  = ldr_win;

    // Memory port follows the winner in the same cycle
    always_comb begin
        mem_en    = core_win | ldr_win;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_win) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (ldr_win) begin
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end
    end

    // Starvation count and read-owner tracking for the next cycle
    always_comb begin
        starve_nxt = '0;
        if (ldr_req && !ldr_win)
            starve_nxt = (starve_cnt == S_MAX) ? S_MAX : starve_cnt + 1'b1;
        rd_owner_nxt = OWN_NONE;
        if (core_win && !core_we)
            rd_owner_nxt = OWN_CORE;
        else if (ldr_win && !ldr_we)
            rd_owner_nxt = OWN_LDR;
    end

    // State registers; reset drops any pending read return
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= '0;
            rd_owner   <= OWN_NONE;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            rd_owner   <= rd_owner_nxt;
        end
    end

    assign core_rvalid = !rst && (rd_owner == OWN_CORE);
    assign ldr_rvalid  = !rst && (rd_owner == OWN_LDR);
    assign core_rdata  = mem_rdata;
    assign ldr_rdata   = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            core_stall_cnt <= '0;
            ldr_grant_cnt  <= '0;
        end else begin
            if (core_req && !core_win && core_stall_cnt != 16'hFFFF)
                core_stall_cnt <= core_stall_cnt + 16'd1;
            if (ldr_win && ldr_grant_cnt != 16'hFFFF)
                ldr_grant_cnt <= ldr_grant_cnt + 16'd1;
        end
    end
`endif

endmodule
